// File: rtl/vie_mem_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and the MEM-stage data requester,
// routing in-order responses back via an owner-tag FIFO. Optional macro: ARB_ROUND_ROBIN_EN.
module vie_mem_arbiter #(
    parameter int MAX_OUTST = 4,
    parameter int PTR_W     = $clog2(MAX_OUTST)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    owner_t             owner_q [MAX_OUTST];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               lock;
    owner_t             locked_owner;
`ifdef ARB_ROUND_ROBIN_EN
    owner_t             last_grant;
`endif

    owner_t             grant;
    owner_t             head_owner;
    logic               grant_req;
    logic               full;
    logic               accept;
    logic               pop;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        grant = OWNER_INST;
        full  = (count == CNT_W'(MAX_OUTST));

        if (lock) begin
            grant = locked_owner;
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            if (i_req && d_req)
                grant = (last_grant == OWNER_INST) ? OWNER_DATA : OWNER_INST;
            else if (d_req)
                grant = OWNER_DATA;
`else
            if (d_req)
                grant = OWNER_DATA;
`endif
        end

        grant_req = (grant == OWNER_DATA) ? d_req : i_req;
        // Reset gates the request so every output reads 0 while reset is held.
        m_req     = grant_req && !full && !reset;
        accept    = m_req && m_addr_ok;
        i_addr_ok = accept && (grant == OWNER_INST);
        d_addr_ok = accept && (grant == OWNER_DATA);

        m_wr    = 1'b0;
        m_size  = 2'd0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        if (m_req) begin
            if (grant == OWNER_DATA) begin
                m_wr    = d_wr;
                m_size  = d_size;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end else begin
                m_size  = 2'd2;
                m_addr  = i_addr;
            end
        end
    end

    // A response with nothing outstanding is a protocol error and is dropped.
    always_comb begin
        head_owner = owner_q[rd_ptr];
        pop        = m_data_ok && (count != '0) && !reset;
        i_data_ok  = pop && (head_owner == OWNER_INST);
        d_data_ok  = pop && (head_owner == OWNER_DATA);
        i_rdata    = i_data_ok ? m_rdata : 32'd0;
        d_rdata    = d_data_ok ? m_rdata : 32'd0;
        busy       = ((count != '0) || lock) && !reset;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            lock         <= 1'b0;
            locked_owner <= OWNER_INST;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);

            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Hold the grant on a stalled address phase so the request cannot be swapped mid-flight.
            lock         <= m_req && !m_addr_ok;
            locked_owner <= grant;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clock) begin
        if (reset)
            last_grant <= OWNER_INST;
        else if (accept)
            last_grant <= grant;
    end
`endif

    // NOTE: the tag storage is not reset; an entry is only read after a handshake has written it.
    always_ff @(posedge clock) begin
        if (accept)
            owner_q[wr_ptr] <= grant;
    end

endmodule

// File: tb/tb_vie_mem_arbiter.sv
// Self-checking bench for vie_mem_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the arbitration rules.
module tb_vie_mem_arbiter;

    localparam int MAX = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_rdata;
    logic        d_req, d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] d_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model: owners of accepted-but-unanswered transactions, in order.
    bit q[$];
    bit mdl_locked = 1'b0;
    bit mdl_lock_owner = 1'b0;
    bit mdl_last = 1'b0;
    bit pend_g, pend_acc, pend_pop, pend_lock;

    always #5 clock = ~clock;

    vie_mem_arbiter #(.MAX_OUTST(MAX), .PTR_W(2)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .m_rdata(m_rdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Let combinational outputs settle, then compare every output to the model.
    task automatic settle();
        bit g, full, mreq, acc, pop, own;
        #2;
        full = (q.size() == MAX);
        if (mdl_locked)
            g = mdl_lock_owner;
        else if (i_req && d_req)
            g = RR ? !mdl_last : 1'b1;
        else
            g = d_req;
        mreq = !reset && !full && (g ? d_req : i_req);
        acc  = mreq && m_addr_ok;
        pop  = !reset && m_data_ok && (q.size() > 0);
        own  = pop ? q[0] : 1'b0;

        chk("m_req", m_req, mreq);
        chk("m_wr", m_wr, mreq && g ? d_wr : 1'b0);
        chk("m_size", m_size, !mreq ? 2'd0 : (g ? d_size : 2'd2));
        chk("m_addr", m_addr, !mreq ? 32'd0 : (g ? d_addr : i_addr));
        chk("m_wdata", m_wdata, mreq && g ? d_wdata : 32'd0);
        chk("i_addr_ok", i_addr_ok, acc && !g);
        chk("d_addr_ok", d_addr_ok, acc && g);
        chk("i_data_ok", i_data_ok, pop && !own);
        chk("d_data_ok", d_data_ok, pop && own);
        chk("i_rdata", i_rdata, pop && !own ? m_rdata : 32'd0);
        chk("d_rdata", d_rdata, pop && own ? m_rdata : 32'd0);
        chk("busy", busy, !reset && (q.size() != 0 || mdl_locked));

        pend_g    = g;
        pend_acc  = acc;
        pend_pop  = pop;
        pend_lock = mreq && !m_addr_ok;
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) begin
            q.delete();
            mdl_locked     = 1'b0;
            mdl_lock_owner = 1'b0;
            mdl_last       = 1'b0;
        end else begin
            if (pend_pop) void'(q.pop_front());
            if (pend_acc) begin
                q.push_back(pend_g);
                mdl_last = pend_g;
            end
            mdl_locked     = pend_lock;
            mdl_lock_owner = pend_g;
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic idle();
        i_req = 0; d_req = 0; d_wr = 0; d_size = 0;
        m_addr_ok = 0; m_data_ok = 0;
    endtask

    initial begin
        reset = 1; i_req = 1; d_req = 1; d_wr = 1; d_size = 2'd1;
        i_addr = 32'h1000; d_addr = 32'h2000; d_wdata = 32'hdead;
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h55;
        #1;
        // Reset held with active inputs: every output stays 0.
        settle(); chk("rst_m_req", m_req, 1'b0); chk("rst_busy", busy, 1'b0); tick();
        cyc();
        reset = 0; idle(); m_rdata = 0;
        cyc();

        // Single fetch, response two cycles after acceptance.
        i_req = 1; i_addr = 32'hbfc00000; m_addr_ok = 1;
        settle(); chk("fetch_addr_ok", i_addr_ok, 1'b1); chk("fetch_m_addr", m_addr, 32'hbfc00000); tick();
        idle();
        settle(); chk("fetch_pulse", i_addr_ok, 1'b0); tick();
        m_data_ok = 1; m_rdata = 32'h24080001;
        settle();
        chk("fetch_data_ok", i_data_ok, 1'b1);
        chk("fetch_rdata", i_rdata, 32'h24080001);
        chk("fetch_d_data_ok", d_data_ok, 1'b0);
        tick();
        idle();

        // Conflict: data wins first, instruction follows.
        i_req = 1; d_req = 1; d_wr = 1; d_addr = 32'h80000010; d_wdata = 32'h12345678;
        d_size = 2'd2; m_addr_ok = 1;
        settle();
        chk("conf_m_addr", m_addr, 32'h80000010);
        chk("conf_d_addr_ok", d_addr_ok, 1'b1);
        chk("conf_i_addr_ok0", i_addr_ok, 1'b0);
        tick();
        d_req = 0;
        settle(); chk("conf_i_addr_ok1", i_addr_ok, 1'b1); tick();
        idle();
        m_data_ok = 1; m_rdata = 32'haaaa0001; cyc();
        m_rdata = 32'haaaa0002; cyc();
        idle();

        // Lock: stalled instruction address phase keeps the port while data waits.
        i_req = 1; i_addr = 32'hbfc00100; d_wr = 0; d_addr = 32'h80000020;
        cyc();
        d_req = 1;
        settle(); chk("lock_m_addr_c2", m_addr, 32'hbfc00100); chk("lock_d_ok_c2", d_addr_ok, 1'b0); tick();
        settle(); chk("lock_m_addr_c3", m_addr, 32'hbfc00100); chk("lock_busy", busy, 1'b1); tick();
        m_addr_ok = 1;
        settle(); chk("lock_i_addr_ok", i_addr_ok, 1'b1); chk("lock_d_addr_ok", d_addr_ok, 1'b0); tick();
        i_req = 0;
        settle(); chk("lock_data_after", d_addr_ok, 1'b1); chk("lock_data_addr", m_addr, 32'h80000020); tick();
        idle();
        m_data_ok = 1; cyc(); cyc();
        idle();

        // Full: four fetches outstanding block the fifth.
        i_req = 1; m_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            i_addr = 32'h100 + 32'(k * 4);
            cyc();
        end
        settle();
        chk("full_m_req", m_req, 1'b0);
        chk("full_i_addr_ok", i_addr_ok, 1'b0);
        chk("full_busy", busy, 1'b1);
        tick();
        m_data_ok = 1; m_rdata = 32'h11; cyc();
        m_rdata = 32'h12;
        settle(); chk("full_push_pop", i_addr_ok, 1'b1); tick();
        m_data_ok = 0; cyc();
        settle(); chk("full_again", m_req, 1'b0); tick();
        idle();
        m_data_ok = 1;
        for (int k = 0; k < 4; k++) cyc();
        settle();
        chk("empty_pop_i", i_data_ok, 1'b0);
        chk("empty_pop_d", d_data_ok, 1'b0);
        chk("empty_busy", busy, 1'b0);
        tick();
        idle();

        // Ordering: inst, data, inst returned in acceptance order.
        m_addr_ok = 1;
        i_req = 1; cyc();
        i_req = 0; d_req = 1; cyc();
        d_req = 0; i_req = 1; cyc();
        idle();
        m_data_ok = 1; m_rdata = 32'h1;
        settle(); chk("ord1_i", i_data_ok, 1'b1); chk("ord1_rdata", i_rdata, 32'h1); chk("ord1_d_rdata", d_rdata, 32'h0); tick();
        m_rdata = 32'h2;
        settle(); chk("ord2_d", d_data_ok, 1'b1); chk("ord2_rdata", d_rdata, 32'h2); chk("ord2_i", i_data_ok, 1'b0); tick();
        m_rdata = 32'h3;
        settle(); chk("ord3_i", i_data_ok, 1'b1); chk("ord3_rdata", i_rdata, 32'h3); tick();
        idle();

        // Reset mid-operation drops everything outstanding.
        i_req = 1; m_addr_ok = 1; cyc(); cyc();
        idle(); reset = 1; cyc();
        reset = 0; m_data_ok = 1; m_rdata = 32'h77;
        settle(); chk("rst_drop_i", i_data_ok, 1'b0); chk("rst_drop_busy", busy, 1'b0); tick();
        idle();

`ifdef ARB_ROUND_ROBIN_EN
        // Round robin: continuous conflict alternates data, inst, data, inst.
        reset = 1; cyc(); reset = 0;
        i_req = 1; d_req = 1; m_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("rr_d_addr_ok", d_addr_ok, (k % 2) == 0);
            chk("rr_i_addr_ok", i_addr_ok, (k % 2) == 1);
            tick();
        end
        idle(); m_data_ok = 1;
        for (int k = 0; k < 4; k++) cyc();
        idle();
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            reset     = ($urandom_range(0, 249) == 0);
            i_req     = ($urandom_range(0, 9) < 7);
            d_req     = ($urandom_range(0, 1) == 1);
            d_wr      = ($urandom_range(0, 1) == 1);
            d_size    = 2'($urandom_range(0, 2));
            i_addr    = $urandom;
            d_addr    = $urandom;
            d_wdata   = $urandom;
            m_addr_ok = ($urandom_range(0, 9) < 6);
            m_data_ok = ($urandom_range(0, 9) < 4);
            m_rdata   = $urandom;
            cyc();
        end
        reset = 0; idle(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vie_mem_arbiter.md
Name: vie_mem_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester and the data (MEM-stage) requester of the 5-stage core.
- Grants the address phase, then records the owner of each accepted transaction in an in-order tag FIFO.
- Routes each returning data_ok/rdata to that owner.
- Sits between the IF/MEM stages and the downstream cache/bridge.

Parameters:
- MAX_OUTST, 4, max accepted-but-unanswered transactions; power of 2, range 2..16.
- PTR_W, 2, log2(MAX_OUTST).

Ports:
- clock input 1 system clock
- reset input 1 synchronous, active-high reset
- i_req input 1 instruction request valid
- i_addr input 32 instruction byte address
- i_addr_ok output 1 instruction address phase accepted
- i_data_ok output 1 instruction read data returned
- i_rdata output 32 instruction read data
- d_req input 1 data request valid
- d_wr input 1 1 = store
- d_size input 2 0 = byte, 1 = half, 2 = word
- d_addr input 32 data byte address
- d_wdata input 32 store data
- d_addr_ok output 1 data address phase accepted
- d_data_ok output 1 data response (read data or write ack)
- d_rdata output 32 load data
- m_req output 1 downstream request
- m_wr output 1 downstream write
- m_size output 2 downstream size
- m_addr output 32 downstream address
- m_wdata output 32 downstream write data
- m_addr_ok input 1 downstream accepted address phase
- m_data_ok input 1 downstream response
- m_rdata input 32 downstream read data
- busy output 1 at least one outstanding transaction, or a locked request pending

Behaviour:
- Reset values:
  - FIFO pointers 0, count 0, lock 0, last_grant 0 (instruction).
  - All outputs 0 during and after reset until inputs change. m_req is 0 because count = 0 and the requests are gated.
- Grant select (combinational when unlocked): d_req wins over i_req (fixed priority). With no request, m_req = 0.
- Instruction requests drive m_wr = 0, m_size = 2, m_wdata = 0.
- full = (count == MAX_OUTST). When full, m_req = 0 and both addr_ok = 0.
- Lock: if m_req = 1 and m_addr_ok = 0, register lock = 1 and locked_owner = granted requester.
  - While locked, grant stays with locked_owner even if the other requester rises.
  - lock clears on the cycle m_addr_ok = 1.
- Address handshake: x_addr_ok = m_addr_ok && grant == x && !full. Exactly one of i_addr_ok/d_addr_ok can be 1 per cycle.
- On each accepted handshake, push the owner bit (0 = inst, 1 = data) at wr_ptr; wr_ptr wraps modulo MAX_OUTST.
- Response routing:
  - On m_data_ok, pop the head owner.
  - If the owner is 0: i_data_ok = 1, i_rdata = m_rdata. Else: d_data_ok = 1, d_rdata = m_rdata.
  - Zero-cycle latency (combinational route). rdata is 0 to the non-owner.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance. Push on a full FIFO cannot occur (gated). Pop with count = 0 is a protocol error: ignored, no data_ok raised, count stays 0.
- Responses return strictly in acceptance order; no reordering.
- Reset mid-operation: everything is cleared immediately. Responses arriving after reset with count = 0 are dropped.
- busy = (count != 0) || lock.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both i_req and d_req are high and unlocked, grant goes to the requester that did not win last_grant. last_grant updates on each accepted handshake.
- Undefined: fixed data priority as above; last_grant is unused and may be optimized away.

Test Plan:
- Single fetch: i_req = 1, i_addr = 0xbfc00000, m_addr_ok = 1 in the same cycle, then m_data_ok 2 cycles later with rdata = 0x24080001 -> i_addr_ok pulses 1 cycle; i_data_ok = 1 with i_rdata = 0x24080001; d_data_ok stays 0.
- Conflict, fixed priority: i_req and d_req high together, d_wr = 1, d_addr = 0x80000010, d_wdata = 0x12345678, d_size = 2 -> m_addr = 0x80000010, d_addr_ok first, i_addr_ok on the next accepted cycle.
- Lock: i_req alone, m_addr_ok held 0 for 3 cycles; d_req rises in cycle 2 -> m_addr stays at the instruction address until accepted; data is granted afterwards.
- Full: issue 4 fetches with no m_data_ok -> 5th request sees m_req = 0 and i_addr_ok = 0. One m_data_ok and a new handshake in the same cycle -> count stays 4.
- Ordering: accept inst, data, inst; return 3 responses with rdata 0x1, 0x2, 0x3 -> i_data_ok (0x1), d_data_ok (0x2), i_data_ok (0x3).
- With ARB_ROUND_ROBIN_EN: i_req and d_req continuously high, m_addr_ok = 1 -> grants alternate data, inst, data, inst.
